ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Sequencer and two-port arbiter in front of the single-port `RAM` block: shares one RAM instance between the instruction-fetch path (read-only) and the load/store path (read/write). It converts each requester's level-held request into a one-cycle `LesenAn`/`SchreibenAn` strobe and waits for the RAM's `DatenBereit`/`DatenGeschrieben` response. It then returns read data and a one-cycle completion pulse to the granted requester. It sits between the processor core and `RAM`; the RAM ports are driven only by this block.

## Interface
- `WORDSIZE`, 32, data width; must match the RAM.
- `WORDS`, 32, RAM depth; power of two; address width `AW = $clog2(WORDS)`.
- `Clock` in 1: sole clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `B_Anfrage` in 1: fetch request, level; held with `B_Adresse` stable until `B_Fertig`.
- `B_Adresse` in AW: fetch address.
- `B_Daten` out WORDSIZE: fetch read data; valid while `B_Fertig`=1.
- `B_Fertig` out 1: fetch completion, one-cycle pulse.
- `D_Anfrage` in 1: load/store request, level; held with all `D_*` inputs stable until `D_Fertig`.
- `D_Schreiben` in 1: 1 = write, 0 = read.
- `D_Adresse` in AW: load/store address.
- `D_DatenRein` in WORDSIZE: write data.
- `D_DatenRaus` out WORDSIZE: load data; valid while `D_Fertig`=1.
- `D_Fertig` out 1: load/store completion, one-cycle pulse.
- `LesenAn`, `SchreibenAn` out 1: RAM strobes.
- `Adresse` out AW, `DatenRein` out WORDSIZE: to the RAM.
- `DatenRaus` in WORDSIZE, `DatenBereit` in 1, `DatenGeschrieben` in 1: from the RAM.
- `Belegt` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ZUGRIFF, WARTEN, QUITT.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner, register its port index, address, write flag and write data, and go to ZUGRIFF.
- ZUGRIFF:
  - Drive exactly one strobe high for exactly one cycle: `SchreibenAn` for a data write, `LesenAn` for any read.
  - Drive `Adresse`/`DatenRein` from the registered values.
  - Go to WARTEN.
- WARTEN:
  - Strobes low; `Adresse`/`DatenRein` keep the registered values.
  - When `DatenBereit` (read) or `DatenGeschrieben` (write) is 1, capture `DatenRaus` into the winner's data output register (reads only) and go to QUITT.
  - Otherwise stay in WARTEN.
- QUITT:
  - The winner's `*_Fertig` is 1 and the other port's is 0.
  - No arbitration takes place in QUITT. A request still high in this cycle is not re-granted, so there is no double grant.
  - Go to IDLE.
- Arbitration:
  - Fixed priority by default: the data port beats the fetch port.
  - See Configuration for round-robin.
- The losing request stays pending. It is served in the next IDLE if it is still asserted.
- Data output registers hold their last captured value between accesses.
- Fetch writes are impossible; `D_Schreiben` is ignored for the fetch port.
- Address wrap is inherent: `WORDS` is a power of two, so there is no out-of-range case.

## Timing
- Reset values:
  - state IDLE.
  - `LesenAn`, `SchreibenAn`, `B_Fertig`, `D_Fertig`, `Belegt` = 0.
  - `Adresse`, `DatenRein`, `B_Daten`, `D_DatenRaus` = 0.
  - Round-robin pointer = fetch port favoured.
- Latency: request sampled in IDLE at cycle 0; strobe in cycle 1; RAM response seen in cycle 2; `*_Fertig` in cycle 3.
- Throughput: IDLE is re-entered in cycle 4, giving at most one access per 4 cycles.
- The one-cycle strobe guarantees that `DatenBereit`/`DatenGeschrieben` have dropped before the next ZUGRIFF, so no stale response is accepted.
- Simultaneous requests in IDLE: exactly one is granted, per the policy.
- A request deasserted before its `*_Fertig` is a protocol violation. The access still completes and `*_Fertig` still pulses.
- Reset mid-access:
  - Immediate return to IDLE with strobes low.
  - A write already strobed into the RAM completes inside the RAM; its `Fertig` is lost.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined:
  - A one-bit pointer records the last winner.
  - On simultaneous requests, the port that did not win last time is granted.
  - The pointer updates only on a grant.
- Not defined: fixed priority, data port first, and no pointer register.

## Structure
- Shared package holds:
  - the state encoding enum (IDLE/ZUGRIFF/WARTEN/QUITT);
  - port index constants `PORT_BEFEHL` = 0 and `PORT_DATEN` = 1.
- One sub-module, `ram_arb_grant`: combinational winner selection plus the optional pointer register, so the policy is isolated under the macro.

## Test plan
- Fetch read only: RAM word 5 = 0xDEADBEEF, `B_Anfrage`=1, `B_Adresse`=5 at cycle 0 -> `LesenAn` high only in cycle 1; `B_Fertig`=1 with `B_Daten`=0xDEADBEEF in cycle 3; `D_Fertig` stays 0.
- Data write then read-back: write 0x12345678 to address 9 -> `SchreibenAn` high one cycle, `D_Fertig` in cycle 3. A read of address 9 issued next -> `D_DatenRaus`=0x12345678.
- Simultaneous fetch (address 1) and data read (address 2), macro undefined -> data port served first (`D_Fertig` cycle 3), fetch served second (`B_Fertig` cycle 7).
- Both ports held continuously for 4 grants, macro defined -> grants alternate fetch, data, fetch, data. Without the macro, the data port wins all 4 and the fetch port is starved.
- Request held high through QUITT -> exactly one `Fertig` pulse per access and no extra strobe.
- `Reset` asserted in WARTEN -> all outputs 0 asynchronously; no `Fertig` pulse; a new request after release is served normally with 4-cycle latency.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the RAM sequencer/arbiter and its grant sub-block.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ZUGRIFF = 2'd1,
    WARTEN  = 2'd2,
    QUITT   = 2'd3
  } state_e;

  localparam logic PORT_BEFEHL = 1'b0;
  localparam logic PORT_DATEN  = 1'b1;

endpackage

// File: rtl/ram_arb_grant.sv
// Winner selection between fetch and data port.
// RAM_ARB_ROUND_ROBIN_EN adds a last-winner pointer; otherwise the data port has fixed priority.
module ram_arb_grant
  import ram_arbiter_pkg::*;
(
`ifdef RAM_ARB_ROUND_ROBIN_EN
  input  logic clk_i,
  input  logic rst_i,
  input  logic grant_i,
`endif
  input  logic b_req_i,
  input  logic d_req_i,
  output logic win_o
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic ptr_q;
  logic ptr_d;

  // Winner: on a tie, the port that did not win last time.
  always_comb begin
    if (b_req_i && d_req_i) begin
      win_o = ~ptr_q;
    end else if (d_req_i) begin
      win_o = PORT_DATEN;
    end else begin
      win_o = PORT_BEFEHL;
    end
    if (grant_i) begin
      ptr_d = win_o;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Last-winner pointer; reset value makes the fetch port favoured first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= PORT_DATEN;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: any data request wins.
  always_comb begin
    if (d_req_i) begin
      win_o = PORT_DATEN;
    end else begin
      win_o = PORT_BEFEHL;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-port sequencer/arbiter in front of a single-port RAM (fetch read-only, data read/write).
// Optional round-robin arbitration with RAM_ARB_ROUND_ROBIN_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter  int WORDSIZE = 32,
  parameter  int WORDS    = 32,
  localparam int AW       = $clog2(WORDS)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                B_Anfrage,
  input  logic [AW-1:0]       B_Adresse,
  output logic [WORDSIZE-1:0] B_Daten,
  output logic                B_Fertig,
  input  logic                D_Anfrage,
  input  logic                D_Schreiben,
  input  logic [AW-1:0]       D_Adresse,
  input  logic [WORDSIZE-1:0] D_DatenRein,
  output logic [WORDSIZE-1:0] D_DatenRaus,
  output logic                D_Fertig,
  output logic                LesenAn,
  output logic                SchreibenAn,
  output logic [AW-1:0]       Adresse,
  output logic [WORDSIZE-1:0] DatenRein,
  input  logic [WORDSIZE-1:0] DatenRaus,
  input  logic                DatenBereit,
  input  logic                DatenGeschrieben,
  output logic                Belegt
);

  state_e              state_q, state_d;
  logic                port_q, port_d;
  logic                wr_q, wr_d;
  logic [AW-1:0]       adr_q, adr_d;
  logic [WORDSIZE-1:0] din_q, din_d;
  logic                lesen_q, lesen_d;
  logic                schreiben_q, schreiben_d;
  logic                b_fertig_q, b_fertig_d;
  logic                d_fertig_q, d_fertig_d;
  logic [WORDSIZE-1:0] b_daten_q, b_daten_d;
  logic [WORDSIZE-1:0] d_daten_q, d_daten_d;
  logic                belegt_q, belegt_d;
  logic                win_s;
  logic                req_wr_s;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic grant_s;
  assign grant_s = (state_q == IDLE) && (B_Anfrage || D_Anfrage);
`endif

  ram_arb_grant u_grant (
`ifdef RAM_ARB_ROUND_ROBIN_EN
    .clk_i   (Clock),
    .rst_i   (Reset),
    .grant_i (grant_s),
`endif
    .b_req_i (B_Anfrage),
    .d_req_i (D_Anfrage),
    .win_o   (win_s)
  );

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    wr_d        = wr_q;
    adr_d       = adr_q;
    din_d       = din_q;
    lesen_d     = 1'b0;
    schreiben_d = 1'b0;
    b_fertig_d  = 1'b0;
    d_fertig_d  = 1'b0;
    b_daten_d   = b_daten_q;
    d_daten_d   = d_daten_q;
    req_wr_s    = (win_s == PORT_DATEN) && D_Schreiben;
    case (state_q)
      IDLE: begin
        if (B_Anfrage || D_Anfrage) begin
          state_d     = ZUGRIFF;
          port_d      = win_s;
          wr_d        = req_wr_s;
          adr_d       = (win_s == PORT_DATEN) ? D_Adresse : B_Adresse;
          din_d       = req_wr_s ? D_DatenRein : din_q;
          lesen_d     = ~req_wr_s;
          schreiben_d = req_wr_s;
        end else begin
          state_d = IDLE;
        end
      end
      ZUGRIFF: begin
        state_d = WARTEN;
      end
      WARTEN: begin
        // Only the response matching the strobed access type is accepted.
        if (wr_q ? DatenGeschrieben : DatenBereit) begin
          state_d    = QUITT;
          b_fertig_d = (port_q == PORT_BEFEHL);
          d_fertig_d = (port_q == PORT_DATEN);
          if (wr_q) begin
            d_daten_d = d_daten_q;
          end else if (port_q == PORT_DATEN) begin
            d_daten_d = DatenRaus;
          end else begin
            b_daten_d = DatenRaus;
          end
        end else begin
          state_d = WARTEN;
        end
      end
      QUITT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    belegt_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      port_q      <= PORT_BEFEHL;
      wr_q        <= 1'b0;
      adr_q       <= {AW{1'b0}};
      din_q       <= {WORDSIZE{1'b0}};
      lesen_q     <= 1'b0;
      schreiben_q <= 1'b0;
      b_fertig_q  <= 1'b0;
      d_fertig_q  <= 1'b0;
      b_daten_q   <= {WORDSIZE{1'b0}};
      d_daten_q   <= {WORDSIZE{1'b0}};
      belegt_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      wr_q        <= wr_d;
      adr_q       <= adr_d;
      din_q       <= din_d;
      lesen_q     <= lesen_d;
      schreiben_q <= schreiben_d;
      b_fertig_q  <= b_fertig_d;
      d_fertig_q  <= d_fertig_d;
      b_daten_q   <= b_daten_d;
      d_daten_q   <= d_daten_d;
      belegt_q    <= belegt_d;
    end
  end

  assign LesenAn     = lesen_q;
  assign SchreibenAn = schreiben_q;
  assign Adresse     = adr_q;
  assign DatenRein   = din_q;
  assign B_Daten     = b_daten_q;
  assign B_Fertig    = b_fertig_q;
  assign D_DatenRaus = d_daten_q;
  assign D_Fertig    = d_fertig_q;
  assign Belegt      = belegt_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: RAM environment plus a transaction-timeline reference model.
module tb_ram_arbiter;

  localparam int WS = 32;
  localparam int WD = 32;
  localparam int AW = 5;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          B_Anfrage, B_Fertig;
  logic [AW-1:0] B_Adresse;
  logic [WS-1:0] B_Daten;
  logic          D_Anfrage, D_Schreiben, D_Fertig;
  logic [AW-1:0] D_Adresse;
  logic [WS-1:0] D_DatenRein, D_DatenRaus;
  logic          LesenAn, SchreibenAn, Belegt;
  logic [AW-1:0] Adresse;
  logic [WS-1:0] DatenRein, DatenRaus;
  logic          DatenBereit, DatenGeschrieben;

  ram_arbiter #(.WORDSIZE(WS), .WORDS(WD)) dut (
    .Clock(Clock), .Reset(Reset),
    .B_Anfrage(B_Anfrage), .B_Adresse(B_Adresse), .B_Daten(B_Daten), .B_Fertig(B_Fertig),
    .D_Anfrage(D_Anfrage), .D_Schreiben(D_Schreiben), .D_Adresse(D_Adresse),
    .D_DatenRein(D_DatenRein), .D_DatenRaus(D_DatenRaus), .D_Fertig(D_Fertig),
    .LesenAn(LesenAn), .SchreibenAn(SchreibenAn), .Adresse(Adresse), .DatenRein(DatenRein),
    .DatenRaus(DatenRaus), .DatenBereit(DatenBereit), .DatenGeschrieben(DatenGeschrieben),
    .Belegt(Belegt)
  );

  always #5 Clock = ~Clock;

  function automatic logic [WS-1:0] init_word(int i);
    if (i == 5) return 32'hDEADBEEF;
    return 32'h1000_0000 + i * 32'h0001_0003;
  endfunction

  // Single-port RAM environment: one-cycle response to each strobe.
  logic [WS-1:0] ram [WD];
  bit            ram_init = 1'b0;
  always @(posedge Clock) begin
    if (Reset) begin
      DatenBereit      <= 1'b0;
      DatenGeschrieben <= 1'b0;
      if (!ram_init) begin
        for (int i = 0; i < WD; i++) ram[i] <= init_word(i);
        ram_init <= 1'b1;
      end
    end else begin
      DatenBereit      <= LesenAn;
      DatenGeschrieben <= SchreibenAn;
      if (LesenAn) DatenRaus <= ram[Adresse];
      if (SchreibenAn) ram[Adresse] <= DatenRein;
    end
  end

  // Reference model: each grant occupies cycles g..g+3, strobe at g+1, done at g+3.
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc;
  bit            m_act;
  int            g_cyc;
  bit            g_port;
  bit            g_wr;
  logic [AW-1:0] g_adr;
  logic [WS-1:0] g_din, g_rdata;
  logic [WS-1:0] shadow [WD];
  logic [WS-1:0] exp_b, exp_d;
  bit            hold_b, hold_d, rnd_mode;
  bit            wins [$];
`ifdef RAM_ARB_ROUND_ROBIN_EN
  bit            rr_last;
`endif

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_grant();
    bit w;
    if (!m_act || cyc >= g_cyc + 4) begin
      if (B_Anfrage || D_Anfrage) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        w = (B_Anfrage && D_Anfrage) ? !rr_last : D_Anfrage;
        rr_last = w;
`else
        w = D_Anfrage;
`endif
        m_act  = 1'b1;
        g_cyc  = cyc;
        g_port = w;
        g_wr   = w && D_Schreiben;
        g_adr  = w ? D_Adresse : B_Adresse;
        g_din  = D_DatenRein;
        if (g_wr) shadow[g_adr] = g_din;
        g_rdata = shadow[g_adr];
      end
    end
  endtask

  task automatic tick();
    bit busy, st, fin;
    if (rnd_mode) begin
      if (!B_Anfrage && $urandom_range(2) == 0) begin
        B_Anfrage = 1'b1;
        B_Adresse = AW'($urandom_range(7));
      end
      if (!D_Anfrage && $urandom_range(2) == 0) begin
        D_Anfrage   = 1'b1;
        D_Schreiben = 1'($urandom_range(1));
        D_Adresse   = AW'($urandom_range(7));
        D_DatenRein = $urandom;
      end
    end
    model_grant();
    @(negedge Clock);
    cyc++;
    busy = m_act && cyc > g_cyc && cyc <= g_cyc + 3;
    st   = m_act && cyc == g_cyc + 1;
    fin  = m_act && cyc == g_cyc + 3;
    if (fin && !g_wr) begin
      if (g_port) exp_d = g_rdata;
      else        exp_b = g_rdata;
    end
    check_eq("LesenAn", LesenAn, st && !g_wr);
    check_eq("SchreibenAn", SchreibenAn, st && g_wr);
    check_eq("Belegt", Belegt, busy);
    check_eq("B_Fertig", B_Fertig, fin && !g_port);
    check_eq("D_Fertig", D_Fertig, fin && g_port);
    check_eq("B_Daten", B_Daten, exp_b);
    check_eq("D_DatenRaus", D_DatenRaus, exp_d);
    if (st) check_eq("Adresse", Adresse, g_adr);
    if (st && g_wr) check_eq("DatenRein", DatenRein, g_din);
    if (fin) begin
      wins.push_back(g_port);
      if (!g_port && !hold_b) B_Anfrage = 1'b0;
      if (g_port && !hold_d) D_Anfrage = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_LesenAn"}, LesenAn, 1'b0);
    check_eq({tag, "_SchreibenAn"}, SchreibenAn, 1'b0);
    check_eq({tag, "_Fertig"}, {B_Fertig, D_Fertig}, 2'b00);
    check_eq({tag, "_Belegt"}, Belegt, 1'b0);
    check_eq({tag, "_Adresse"}, Adresse, 5'd0);
    check_eq({tag, "_DatenRein"}, DatenRein, 32'd0);
    check_eq({tag, "_B_Daten"}, B_Daten, 32'd0);
    check_eq({tag, "_D_DatenRaus"}, D_DatenRaus, 32'd0);
  endtask

  task automatic model_reset();
    m_act = 1'b0;
    exp_b = 32'd0;
    exp_d = 32'd0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    rr_last = 1'b1;
`endif
  endtask

  initial begin
    Reset = 1'b1;
    B_Anfrage = 1'b0; B_Adresse = 5'd0;
    D_Anfrage = 1'b0; D_Schreiben = 1'b0; D_Adresse = 5'd0; D_DatenRein = 32'd0;
    hold_b = 1'b0; hold_d = 1'b0; rnd_mode = 1'b0;
    g_cyc = 0; g_port = 1'b0; g_wr = 1'b0; g_adr = 5'd0; g_din = 32'd0; g_rdata = 32'd0;
    for (int i = 0; i < WD; i++) shadow[i] = init_word(i);
    model_reset();
    cyc = 0;
    repeat (3) @(negedge Clock);
    check_all_zero("reset");
    Reset = 1'b0;
    tick();

    // Fetch read of word 5.
    B_Anfrage = 1'b1; B_Adresse = 5'd5;
    repeat (5) tick();
    check_eq("fetch_word5", B_Daten, 32'hDEADBEEF);

    // Data write then read-back of address 9.
    D_Anfrage = 1'b1; D_Schreiben = 1'b1; D_Adresse = 5'd9; D_DatenRein = 32'h12345678;
    repeat (5) tick();
    D_Anfrage = 1'b1; D_Schreiben = 1'b0;
    repeat (5) tick();
    check_eq("readback_9", D_DatenRaus, 32'h12345678);

    // Simultaneous fetch (1) and data read (2).
    wins.delete();
    B_Anfrage = 1'b1; B_Adresse = 5'd1;
    D_Anfrage = 1'b1; D_Schreiben = 1'b0; D_Adresse = 5'd2;
    repeat (10) tick();
    check_eq("simul_count", wins.size(), 2);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    check_eq("simul_first", {31'd0, wins[0]}, 0);
    check_eq("simul_second", {31'd0, wins[1]}, 1);
`else
    check_eq("simul_first", {31'd0, wins[0]}, 1);
    check_eq("simul_second", {31'd0, wins[1]}, 0);
`endif

    // Both ports held continuously for four grants, request held through QUITT.
    wins.delete();
    hold_b = 1'b1; hold_d = 1'b1;
    B_Anfrage = 1'b1; D_Anfrage = 1'b1; D_Schreiben = 1'b0;
    repeat (16) tick();
    check_eq("held_count", wins.size(), 4);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    check_eq("held_order", {wins[0], wins[1], wins[2], wins[3]}, 4'b0101);
`else
    check_eq("held_order", {wins[0], wins[1], wins[2], wins[3]}, 4'b1111);
`endif
    hold_b = 1'b0; hold_d = 1'b0;
    B_Anfrage = 1'b0; D_Anfrage = 1'b0;
    repeat (2) tick();

    // Reset asserted while waiting for a write response.
    D_Anfrage = 1'b1; D_Schreiben = 1'b1; D_Adresse = 5'd3; D_DatenRein = 32'hCAFEF00D;
    repeat (2) tick();
    Reset = 1'b1;
    D_Anfrage = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    repeat (2) tick();
    Reset = 1'b0;
    B_Anfrage = 1'b1; B_Adresse = 5'd3;
    repeat (5) tick();
    check_eq("post_reset_fetch", B_Daten, 32'hCAFEF00D);

    // Randomized traffic against the model.
    rnd_mode = 1'b1;
    repeat (800) tick();
    rnd_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
